// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, one bit per clock, LSB first.
// A single full-subtractor slice plus a registered borrow walks through
// the operands; the result is assembled in a right-shifting register.
// Optional feature macro: SERIAL_SUB_SAT_EN (unsigned saturating subtract:
// diff is forced to 0 at done when the final borrow is 1).
//
// Handshake: start is sampled only while busy=0 (state IDLE). An accepted
// start captures a/b; busy is high for exactly WIDTH cycles; done is a
// one-cycle pulse in the cycle after the last slice, with diff/bout valid
// and held until the next done. start while busy=1 is dropped, not queued.
// d_valid qualifies d_bit, one streamed difference bit per RUN cycle.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             d_bit,
    output logic             d_valid,
    output logic             dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             d_bit_q, d_bit_d;
    logic             d_valid_q, d_valid_d;

    logic             slice_diff;
    logic             slice_bout;
    logic [WIDTH-1:0] full_res;

    // Full-subtractor slice on the current LSBs and the carried borrow
    always_comb begin
        slice_diff = sa_q[0] ^ sb_q[0] ^ borrow_q;
        slice_bout = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & borrow_q);
    end

    // Result as it stands once the current slice bit is shifted in
    assign full_res = {slice_diff, res_q[WIDTH-1:1]};

    // State register and datapath flops; reset clears everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            res_q     <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            bout_q    <= 1'b0;
            done_q    <= 1'b0;
            d_bit_q   <= 1'b0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            res_q     <= res_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
            borrow_q  <= borrow_d;
            bout_q    <= bout_d;
            done_q    <= done_d;
            d_bit_q   <= d_bit_d;
            d_valid_q <= d_valid_d;
        end
    end

    // Next-state and datapath update; done/d_valid default low so they pulse
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        res_d     = res_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        borrow_d  = borrow_q;
        bout_d    = bout_q;
        done_d    = 1'b0;
        d_bit_d   = d_bit_q;
        d_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d     = a;
                    sb_d     = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                sa_d      = sa_q >> 1;
                sb_d      = sb_q >> 1;
                res_d     = full_res;
                borrow_d  = slice_bout;
                d_bit_d   = slice_diff;
                d_valid_d = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Counter is left at its last value; IDLE reloads it
                    state_d = IDLE;
                    done_d  = 1'b1;
                    bout_d  = slice_bout;
`ifdef SERIAL_SUB_SAT_EN
                    diff_d  = slice_bout ? '0 : full_res;
`else
                    diff_d  = full_res;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == RUN);
    assign dbg_state = state_q;
    assign done      = done_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign d_bit     = d_bit_q;
    assign d_valid   = d_valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor
// against an arithmetic reference model (a - b mod 2^W, borrow = a < b).
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, bout, d_bit, d_valid, dbg_state;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;

    // Last result the DUT should be holding on diff/bout
    logic [W-1:0] held_diff = '0;
    logic         held_bout = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .bout      (bout),
        .d_bit     (d_bit),
        .d_valid   (d_valid),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: modular difference and unsigned borrow
    function automatic logic [W-1:0] ref_raw(input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned m;
        m = (int'(av) - int'(bv) + (1 << W)) % (1 << W);
        return W'(m);
    endfunction

    function automatic logic ref_borrow(input logic [W-1:0] av, input logic [W-1:0] bv);
        return av < bv;
    endfunction

    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef SERIAL_SUB_SAT_EN
        if (av < bv) return '0;
`endif
        return ref_raw(av, bv);
    endfunction

    // Drives start with operands at the current negedge and follows the
    // operation to done. hold keeps start/a/b asserted throughout; poke_k>0
    // fires a second start (1,2) at that cycle to confirm it is ignored.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit hold, input int poke_k);
        int           k;
        int           nbits;
        logic [W-1:0] bits;
        bit           held_ok;
        bits    = '0;
        nbits   = 0;
        held_ok = 1'b1;
        start = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        k = 0;
        if (!hold) begin
            start = 1'b0;
            a     = W'($urandom);
            b     = W'($urandom);
        end
        check_eq("busy_after_start", busy, 1);
        forever begin
            if (d_valid) begin
                if (nbits < W) bits[nbits] = d_bit;
                nbits++;
            end
            if (done) break;
            if (diff !== held_diff || bout !== held_bout) held_ok = 1'b0;
            if (k > W + 2) break;
            if (!hold) start = (k == poke_k) ? 1'b1 : 1'b0;
            if (k == poke_k) begin
                a = W'(1);
                b = W'(2);
            end
            @(negedge clk);
            k++;
        end
        if (!hold) start = 1'b0;
        check_eq("done_seen", done, 1);
        check_eq("done_latency", k, W);
        check_eq("result_held", held_ok, 1);
        check_eq("d_valid_count", nbits, W);
        check_eq("d_bit_stream", bits, ref_raw(av, bv));
        check_eq("diff", diff, ref_diff(av, bv));
        check_eq("bout", bout, ref_borrow(av, bv));
        held_diff = ref_diff(av, bv);
        held_bout = ref_borrow(av, bv);
        if (!hold) begin
            @(negedge clk);
            check_eq("done_pulse_clear", done, 0);
            check_eq("d_valid_clear", d_valid, 0);
            check_eq("busy_clear", busy, 0);
            check_eq("diff_held_after", diff, held_diff);
        end
    endtask

    // Stimulus and checks
    initial begin
        logic [W-1:0] ra, rb;
        int           gap;
        bit           no_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_diff", diff, 0);
        check_eq("reset_bout", bout, 0);
        check_eq("reset_d_valid", d_valid, 0);
        check_eq("reset_d_bit", d_bit, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic operation and edge operands
        run_op(8'd100, 8'd37, 1'b0, -1);
        run_op(8'd5,   8'd9,  1'b0, -1);
        run_op(8'hFF,  8'hFF, 1'b0, -1);
        run_op(8'h00,  8'h01, 1'b0, -1);
        run_op(8'h80,  8'h00, 1'b0, -1);

        // Start while busy is ignored
        run_op(8'd50, 8'd20, 1'b0, 3);
        check_eq("no_extra_op", busy, 0);

        // Reset in the middle of a run
        start = 1'b1;
        a     = 8'd200;
        b     = 8'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_d_valid", d_valid, 0);
        check_eq("rst_mid_diff", diff, 0);
        check_eq("rst_mid_bout", bout, 0);
        check_eq("rst_mid_done", done, 0);
        held_diff = '0;
        held_bout = 1'b0;
        no_done   = 1'b1;
        repeat (W + 2) begin
            if (done) no_done = 1'b0;
            @(negedge clk);
        end
        check_eq("rst_mid_no_done", no_done, 1);
        run_op(8'd7, 8'd3, 1'b0, -1);

        // start held through done: back-to-back operations
        run_op(8'd10, 8'd4, 1'b1, -1);
        run_op(8'd10, 8'd4, 1'b1, -1);
        start = 1'b0;
        @(negedge clk);
        check_eq("b2b_idle", busy, 0);
        check_eq("b2b_diff_held", diff, 6);

        // Randomized operations with random idle gaps
        for (int i = 0; i < 24; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            if (i % 6 == 0) rb = ra;
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            run_op(ra, rb, 1'b0, (i % 4 == 1) ? int'($urandom_range(1, W - 1)) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing a − b, one bit per clock, LSB first. It is built around a single full-subtractor cell: diff = x^y^bin, bout = (~x&y) | (~(x^y)&bin). A registered borrow carries between bit slices. It is the area-minimal counterpart to the adder datapaths, for use where throughput is not critical. A start/busy/done handshake wraps the datapath, and a streamed per-bit output is exposed for downstream serial consumers.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  minuend; captured on the accepted start edge.
b  input  WIDTH  subtrahend; captured on the accepted start edge.
busy  output  1  high while bits are being processed.
done  output  1  one-cycle pulse; diff and bout are valid.
diff  output  WIDTH  result a − b mod 2^WIDTH; held until the next done.
bout  output  1  final borrow (1 when a < b unsigned); held with diff.
d_bit  output  1  current serial difference bit.
d_valid  output  1  d_bit qualifier; high for exactly WIDTH cycles per operation.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE. busy, done, diff, bout, d_bit, d_valid, borrow register, bit counter and shift registers all = 0. Reset overrides every other input.
- States: IDLE, RUN. No separate DONE state; done is a registered pulse.
- IDLE: on an edge with start=1, load sa<=a, sb<=b, borrow<=0, cnt<=0, and go to RUN. busy=1 from the next cycle.
- RUN, each edge:
  - Compute slice from sa[0], sb[0] and borrow.
  - Shift the slice diff bit into the MSB of the result shift register, shifting right.
  - Shift sa and sb right. borrow <= slice bout. cnt <= cnt+1.
  - d_bit <= slice diff; d_valid <= 1.
- Last slice (cnt == WIDTH−1): state <= IDLE, busy <= 0, done <= 1, diff <= full result, bout <= slice bout.
- Latency: done is high in the cycle that starts WIDTH edges after the start-sampling edge. For WIDTH=8, start sampled at edge 0 gives bits at edges 1..8 and done visible after edge 8.
- done and d_valid self-clear on the next edge unless re-asserted.
- start while busy=1: ignored. Operands are not re-captured and there is no queueing.
- start=1 in the done cycle: accepted, because the state is already IDLE. The next operation begins back-to-back, and diff/bout keep the previous result until the new done.
- Changes on a/b after capture have no effect.
- cnt width is $clog2(WIDTH). The counter never wraps, because the last slice returns to IDLE.
- Reset mid-RUN: abort immediately. No done is produced and all outputs read 0 next cycle.

Optional Feature:
SERIAL_SUB_SAT_EN:
- Defined: unsigned saturating subtract. If the final borrow is 1, diff is forced to 0 at done; bout still reports 1. d_bit streams the unsaturated bits regardless.
- Undefined: diff is the modular result; no saturation logic is present.

Test Plan:
1. WIDTH=8, a=100, b=37, start one cycle -> busy for 8 cycles; done exactly 8 edges after start; diff=63, bout=0; d_bit sequence LSB-first = 1,1,1,1,1,1,0,0.
2. a=5, b=9 -> diff=0xFC, bout=1; with SERIAL_SUB_SAT_EN defined, diff=0x00, bout=1.
3. Edge operands:
   - a=0xFF, b=0xFF -> diff=0x00, bout=0.
   - a=0x00, b=0x01 -> diff=0xFF, bout=1.
   - a=0x80, b=0x00 -> diff=0x80, bout=0.
4. start with a=50, b=20, then start again at cycle 3 with a=1, b=2 -> second start ignored; single done with diff=30; d_valid high exactly 8 cycles.
5. rst asserted during RUN after 4 bits -> next cycle busy=0, d_valid=0, diff=0, bout=0; no done. A fresh start with a=7, b=3 gives diff=4 after 8 cycles.
6. start held high through the done cycle of a=10, b=4 -> done with diff=6, second operation begins immediately, second done exactly 8 cycles later with diff=6 (same operands held). diff holds 6 between the two dones.
